// File: rtl/pp_shift_add_mult.sv
// pp_shift_add_mult
//   Sequential unsigned shift-add multiplier. One operand bit is consumed
//   per RUN cycle. The accumulator adder is a WIDTH-bit ripple chain whose
//   lowest APPROX_BITS positions use approximate cells (cout = x|y). The
//   adder is only enabled (add_en) on cycles where the current multiplier
//   bit is 1. Cycles that skip the add are counted in skip_cnt.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; in_ready = 1
//   RUN   | WIDTH add/shift iterations; add_en = Q[0]
//   DONE  | product = {A,Q} held with out_valid = 1 until out_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start / in_ready    request handshake (accepted only in IDLE)
//   a, b                multiplicand / multiplier (unsigned, WIDTH bits)
//   product / out_valid result (2*WIDTH bits) and its valid flag
//   out_ready           downstream consumes product (only used in DONE)
//   add_en              accumulator adder clock-gate enable this cycle
//   skip_cnt            wrapping count of RUN cycles with the add gated off
module pp_shift_add_mult #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               add_en,
  output logic [15:0]        skip_cnt
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, q_q, a_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum;
  logic             sum_c;
  logic             last_iter;

  assign last_iter = (cnt_q == LAST);
  assign product   = {a_q, q_q};

  // Ripple-carry A + M, carry-in 0. Low positions are approximate cells
  // whose carry ignores the incoming carry.
  always_comb begin
    logic cy;
    cy  = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a_q[i] ^ m_q[i] ^ cy;
      if (i < APPROX_BITS) begin
        cy = a_q[i] | m_q[i];
      end else begin
        cy = (a_q[i] & m_q[i]) | (a_q[i] & cy) | (m_q[i] & cy);
      end
    end
    sum_c = cy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        add_en = q_q[0];
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. {C,A,Q} shifts right with 0 entering the MSB, so C is always
  // 0 between iterations; it only carries the adder's carry-out into A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      skip_cnt <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        m_q   <= a;
        q_q   <= b;
        a_q   <= '0;
        c_q   <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        if (q_q[0]) begin
          {c_q, a_q, q_q} <= {1'b0, sum_c, sum, q_q[WIDTH-1:1]};
        end else begin
          {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
          skip_cnt        <= skip_cnt + 16'd1;
        end
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pp_shift_add_mult.sv
module tb_pp_shift_add_mult;

  localparam int W = 8;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b1;
  logic           start     = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;

  logic           in_ready_x, out_valid_x, add_en_x;
  logic [2*W-1:0] product_x;
  logic [15:0]    skip_x;
  logic           in_ready_p, out_valid_p, add_en_p;
  logic [2*W-1:0] product_p;
  logic [15:0]    skip_p;

  int             n_assert = 0;
  int             n_fail   = 0;
  logic [15:0]    skip_model = '0;

  always #5 clk = ~clk;

  // Exact instance and fully approximate instance driven in lockstep.
  pp_shift_add_mult #(.WIDTH(W), .APPROX_BITS(0)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready_x),
    .a(a), .b(b), .product(product_x), .out_valid(out_valid_x),
    .out_ready(out_ready), .add_en(add_en_x), .skip_cnt(skip_x)
  );

  pp_shift_add_mult #(.WIDTH(W), .APPROX_BITS(W)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready_p),
    .a(a), .b(b), .product(product_p), .out_valid(out_valid_p),
    .out_ready(out_ready), .add_en(add_en_p), .skip_cnt(skip_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Adder with the low nap positions using carry = x|y.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input int nap);
    logic [W:0] r;
    logic       c;
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c = (i < nap) ? (x[i] | y[i]) : ((x[i] & y[i]) | (x[i] & c) | (y[i] & c));
    end
    r[W] = c;
    return r;
  endfunction

  // Shift-add multiplication on a (2W+1)-bit integer accumulator.
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y, input int nap);
    logic [2*W:0] acc;
    acc = {{(W+1){1'b0}}, y};
    for (int k = 0; k < W; k++) begin
      if (acc[0]) acc[2*W:W] = ref_add(acc[2*W-1:W], x, nap);
      acc = acc >> 1;
    end
    return acc[2*W-1:0];
  endfunction

  // Caller is in IDLE, away from a rising edge. hold = cycles out_ready is
  // kept low in DONE; poke = fire stray start pulses during RUN and DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold,
                        input bit poke, input string tag,
                        output logic [2*W-1:0] px, output logic [2*W-1:0] pp);
    int             edges;
    int             adds;
    logic [2*W-1:0] ex, ep;
    ex = ta * tb_;
    ep = ref_mult(ta, tb_, W);
    chk({tag, ":in_ready"}, in_ready_x, 1);
    a = ta; b = tb_; start = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    adds  = 0;
    while (!out_valid_x && edges < 4 * W) begin
      if (add_en_x) adds++;
      if (poke && edges == 3) begin
        start = 1'b1; a = ~ta; b = ~tb_;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, ":latency"}, edges, W + 1);
    chk({tag, ":add_cycles"}, adds, popc(tb_));
    chk({tag, ":out_valid"}, out_valid_x, 1);
    chk({tag, ":prod_exact"}, product_x, ex);
    chk({tag, ":prod_approx"}, product_p, ep);
    skip_model = skip_model + 16'(W - popc(tb_));
    chk({tag, ":skip_x"}, skip_x, skip_model);
    chk({tag, ":skip_p"}, skip_p, skip_model);
    px = product_x;
    pp = product_p;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        start = 1'b1; a = ta ^ 8'h5a; b = tb_ ^ 8'ha5;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, ":hold_valid"}, out_valid_x, 1);
      chk({tag, ":hold_prod"}, product_x, ex);
      chk({tag, ":hold_add_en"}, add_en_x, 0);
    end
    if (hold > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, ":valid_drop"}, out_valid_x, 0);
    chk({tag, ":idle_ready"}, in_ready_x, 1);
    chk({tag, ":idle_add_en"}, add_en_x, 0);
  endtask

  initial begin
    logic [2*W-1:0] px, pp;
    logic [W-1:0]   ra, rb;
    bit             seen;
    bit             ok;
    int             w;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst:in_ready", in_ready_x, 1);
    chk("rst:out_valid", out_valid_x, 0);
    chk("rst:add_en", add_en_x, 0);
    chk("rst:product", product_x, 0);
    chk("rst:skip", skip_x, 0);

    // First op issued on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd13, 8'd11, 0, 0, "op13x11", px, pp);
    chk("op13x11:value", px, 143);
    chk("op13x11:skip5", skip_x, 5);

    run_op(8'd255, 8'd255, 0, 0, "op255", px, pp);
    chk("op255:value", px, 65025);
    chk("op255:skip_unchanged", skip_x, 5);

    run_op(8'd1, 8'd1, 0, 0, "op1x1", px, pp);
    chk("op1x1:approx_value", pp, 3);
    run_op(8'd0, 8'd0, 0, 0, "op0x0", px, pp);
    chk("op0x0:approx_value", pp, 0);
    chk("op0x0:skip_plus8", skip_p, 5 + 7 + 8);

    // Back-pressure in DONE with stray start pulses
    run_op(8'h5a, 8'hc3, 5, 1, "hold_poke", px, pp);

    // Reset during RUN after four iterations
    @(negedge clk);
    a = 8'h9d; b = 8'hb7; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort:in_ready", in_ready_x, 1);
    chk("abort:out_valid", out_valid_x, 0);
    chk("abort:add_en", add_en_x, 0);
    chk("abort:product_x", product_x, 0);
    chk("abort:product_p", product_p, 0);
    chk("abort:skip", skip_x, 0);
    skip_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_x || out_valid_p) seen = 1'b1;
    end
    chk("abort:no_pulse", seen, 0);
    chk("abort:still_idle", in_ready_x, 1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_op(8'd7, 8'd6, 0, 0, "after_rst", px, pp);
    chk("after_rst:value", px, 42);

    // Randomized operands
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), "rand", px, pp);
    end

    // skip_cnt wrap: 8191 ops with b=0 (8 skips each), then one with 6 skips
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    skip_model = '0;
    a = 8'h3c; b = '0; start = 1'b1; out_ready = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 8191 && ok; k++) begin
      w = 0;
      while (!out_valid_x && w < 30) begin
        @(negedge clk);
        w++;
      end
      if (w >= 30) begin
        chk("preload:timeout", out_valid_x, 1);
        ok = 1'b0;
      end
      if (k == 8190 || !ok) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    skip_model = 16'(8 * 8191);
    chk("preload:skip", skip_x, skip_model);
    run_op(8'h21, 8'h03, 0, 0, "pre_wrap", px, pp);
    chk("pre_wrap:fffe", skip_x, 16'hfffe);
    run_op(8'h44, 8'h00, 0, 0, "wrap", px, pp);
    chk("wrap:0006", skip_x, 16'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_shift_add_mult.md
PP_SHIFT_ADD_MULT -- requirements
Module: pp_shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..16.
REQ-002 SHALL have parameter APPROX_BITS, default 0: number of LSB adder positions built as approximate cells, legal range 0..WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new multiplication.
REQ-006 SHALL have port in_ready, output, 1 bit: block is able to accept start.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand, unsigned.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier, unsigned.
REQ-009 SHALL have port product, output, 2*WIDTH bits: result; valid only while out_valid is 1.
REQ-010 SHALL have port out_valid, output, 1 bit: product is available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes product.
REQ-012 SHALL have port add_en, output, 1 bit: clock-gate enable for the accumulator adder in the current cycle.
REQ-013 SHALL have port skip_cnt, output, 16 bits: running count of gated (skipped) add cycles.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready = 1 only in IDLE.
REQ-016 SHALL take the transition IDLE -> RUN on a clock edge where start = 1 and in_ready = 1, and on that edge load M <= a, Q <= b, A <= 0, C <= 0 and iteration counter <= 0.
REQ-017 SHALL ignore start in RUN and DONE: no reload and no effect on the result.
REQ-018 SHALL, on each edge in RUN: if Q[0] = 1, compute {C,A} = A + M through a WIDTH-bit ripple chain with carry-in 0; then shift the concatenation {C,A,Q} right by 1, with a 0 entering at the MSB.
REQ-019 SHALL make ripple bit i (i < APPROX_BITS) an approximate cell with sum = x^y^cin and cout = x|y.
REQ-020 SHALL make ripple bit i (i >= APPROX_BITS) an exact cell with sum = x^y^cin and cout = majority(x,y,cin).
REQ-021 SHALL, when Q[0] = 0 in RUN, hold A and C through the add step; only the shift occurs.
REQ-022 SHALL drive add_en = 1 exactly when the state is RUN and Q[0] = 1; add_en SHALL be 0 in IDLE and DONE.
REQ-023 SHALL increment skip_cnt by 1 on every RUN edge where Q[0] = 0; skip_cnt SHALL wrap from 0xFFFF to 0 and SHALL NOT clear on new operations.
REQ-024 SHALL take the transition RUN -> DONE on the WIDTH-th RUN edge, so out_valid rises WIDTH+1 edges after the accepting edge.
REQ-025 SHALL, in DONE, hold out_valid = 1 and product = {A,Q} stable until out_ready = 1.
REQ-026 SHALL take the transition DONE -> IDLE on an edge where out_ready = 1, and drop out_valid on that edge.
REQ-027 SHALL have a minimum back-to-back issue interval of WIDTH+2 cycles.
REQ-028 SHALL, with APPROX_BITS = 0, make product exactly equal to a*b for all inputs.
REQ-029 SHALL ignore out_ready outside DONE.

Reset
REQ-030 SHALL, while rst_n = 0, force: state IDLE, in_ready 1, out_valid 0, add_en 0, product 0, skip_cnt 0, and A, Q, M, C and the iteration counter all 0.
REQ-031 SHALL, when reset is asserted mid-RUN or in DONE, abort the operation immediately, with no output pulse after release.
REQ-032 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: WIDTH=8, APPROX_BITS=0, a=13, b=11, out_ready=1 -> out_valid on the 9th edge after acceptance, product=143, skip_cnt=5, add_en high for 3 cycles.
REQ-034 SHALL cover: WIDTH=8, APPROX_BITS=0, a=255, b=255 -> product=65025, skip_cnt unchanged.
REQ-035 SHALL cover: WIDTH=8, APPROX_BITS=8, a=1, b=1 -> product=3 (the approximate carry error); a=0, b=0 -> product=0, skip_cnt +8.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> product stable and out_valid=1 throughout; start pulses during RUN/DONE ignored; IDLE after out_ready.
REQ-037 SHALL cover: rst_n pulsed low at RUN edge 4 -> all outputs reset at once; a new op a=7, b=6 after release -> product=42.
REQ-038 SHALL cover: preload skip_cnt to 0xFFFE via repeated b=0 ops, then b=0 -> skip_cnt wraps to 0x0006; randomized exact-mode results checked against a*b.
